// File: rtl/count_bcd_display_pkg.sv
// Shared types and constants for the BCD display path: FSM states,
// active-low seven-segment codes (gfedcba) and iteration-counter sizing.
package count_bcd_display_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Default binary width and the matching iteration counter width; the
    // counter must hold WIDTH itself, hence the +1.
    localparam int BIN_W = 13;
    localparam int CNT_W = $clog2(BIN_W + 1);

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// One BCD digit to active-low seven-segment code, with a blank override.
// Codes 10-15 are unreachable from the converter and show all-off.
module bcd_to_seg
    import count_bcd_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    // Digit lookup; blank wins over the digit value.
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            unique case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/count_bcd_display.sv
// Sequential double-dabble converter feeding DIGITS seven-segment decoders.
// One shift per CONVERT cycle, then a DONE cycle latches bcd/hex and pulses
// valid. Outputs are all registered and hold until the next DONE.
module count_bcd_display
    import count_bcd_display_pkg::*;
#(
    parameter int WIDTH  = 13,
    parameter int DIGITS = 4,
    parameter int LZB    = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int CW = cnt_width(WIDTH);
    localparam int AW = 4 * DIGITS;
    localparam int HW = 7 * DIGITS;

    // The largest binary input must fit in DIGITS decimal digits.
    if (((longint'(1) << WIDTH) - 1) >= pow10(DIGITS)) begin : g_range_bad
        $error("count_bcd_display: DIGITS too small for WIDTH");
    end

    // Reset display: a lone "0" in digit 0, higher digits blank or "0".
    function automatic logic [HW-1:0] hex_reset();
        logic [HW-1:0] h;
        h = '0;
        for (int i = 0; i < DIGITS; i++)
            h[i*7 +: 7] = (i == 0 || LZB == 0) ? SEG_0 : SEG_BLANK;
        return h;
    endfunction

    localparam logic [HW-1:0] HEX_RST = hex_reset();

    state_t          state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic [AW-1:0]   bcd_q, bcd_d;
    logic [HW-1:0]   hex_q, hex_d;

    logic [AW-1:0]     acc_adj;
    logic [DIGITS-1:0] blank;
    logic [HW-1:0]     seg_w;

    // Add-3 correction on every digit >= 5 ahead of the shift.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < DIGITS; i++)
            if (acc_q[i*4 +: 4] >= 4'd5)
                acc_adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
    end

    // Leading-zero blanking: a zero digit is blanked only while every higher
    // digit is also zero. Digit 0 always shows.
    always_comb begin
        logic hz;
        blank = '0;
        hz    = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            blank[i] = (LZB != 0) && hz && (acc_q[i*4 +: 4] == 4'd0);
            hz       = hz && (acc_q[i*4 +: 4] == 4'd0);
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        bcd_to_seg u_seg (
            .digit (acc_q[g*4 +: 4]),
            .blank (blank[g]),
            .seg   (seg_w[g*7 +: 7])
        );
    end

    // Next-state logic: load on start, shift WIDTH times, publish in DONE.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        bcd_d   = bcd_q;
        hex_d   = hex_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sh_d    = bin;
                    acc_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                {acc_d, sh_d} = {acc_adj, sh_q} << 1;
                cnt_d         = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = DONE;
            end
            DONE: begin
                bcd_d   = acc_q;
                hex_d   = seg_w;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            sh_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            bcd_q   <= '0;
            hex_q   <= HEX_RST;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            bcd_q   <= bcd_d;
            hex_q   <= hex_d;
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign bcd   = bcd_q;
    assign hex   = hex_q;

endmodule

// File: tb/tb_count_bcd_display.sv
// Scoreboard bench for count_bcd_display: the driver pushes expected
// bcd/hex/valid-cycle per accepted start, the monitor pops on each valid.
module tb_count_bcd_display;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [12:0] bin;
    logic        busy;
    logic        valid;
    logic [15:0] bcd;
    logic [27:0] hex;

    typedef struct {
        logic [15:0] bcd;
        logic [27:0] hex;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    localparam logic [27:0] HEX_RST = {7'h7F, 7'h7F, 7'h7F, 7'h40};

    count_bcd_display #(.WIDTH(13), .DIGITS(4), .LZB(1)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .bin    (bin),
        .busy   (busy),
        .valid  (valid),
        .bcd    (bcd),
        .hex    (hex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    // Independent decimal model used for the ramp vectors.
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
            4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
            8: return 7'h00; 9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic exp_t model(input int v);
        exp_t e;
        int   d [4];
        bit   hz;
        d[0] = v % 10; d[1] = (v / 10) % 10; d[2] = (v / 100) % 10; d[3] = v / 1000;
        e.bcd = {4'(d[3]), 4'(d[2]), 4'(d[1]), 4'(d[0])};
        hz = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            if (i > 0 && hz && d[i] == 0) e.hex[i*7 +: 7] = 7'h7F;
            else                          e.hex[i*7 +: 7] = seg_of(d[i]);
            if (d[i] != 0) hz = 1'b0;
        end
        e.cyc = 0;
        return e;
    endfunction

    // Monitor: every valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 32'(valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("bcd", 32'(bcd), 32'(e.bcd));
                chk("hex", 32'(hex), 32'(e.hex));
                chk("valid_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Issue one start at an idle cycle; expected result is pushed at accept.
    task automatic conv(input logic [12:0] b, input logic [15:0] eb,
                        input logic [27:0] eh, input bit push, output int acc);
        exp_t e;
        wait_idle();
        start = 1'b1;
        bin   = b;
        @(posedge clk); #1;
        acc = cyc;
        if (push) begin
            e.bcd = eb; e.hex = eh; e.cyc = acc + 14;
            sb.push_back(e);
        end
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    initial begin
        int   acc;
        exp_t e;
        int   n;
        resetn = 1'b0;
        start  = 1'b0;
        bin    = '0;
        #12;
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_bcd",   32'(bcd),   32'd0);
        chk("rst_hex",   32'(hex),   32'(HEX_RST));
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // Directed vectors with hand-derived digits.
        conv(13'd0,    16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b1, acc);
        conv(13'd8191, 16'h8191, {7'h00, 7'h79, 7'h10, 7'h79}, 1'b1, acc);
        conv(13'd5,    16'h0005, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 1'b1, acc);
        conv(13'd1009, 16'h1009, {7'h79, 7'h40, 7'h40, 7'h10}, 1'b1, acc);

        // Starts during CONVERT are ignored; a start at the IDLE cycle lands.
        conv(13'd42, 16'h0042, {7'h7F, 7'h7F, 7'h19, 7'h24}, 1'b1, acc);
        repeat (2) @(posedge clk);
        #1 start = 1'b1; bin = 13'd99;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 start = 1'b1; bin = 13'd99;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; bin = 13'd77;
        e.bcd = 16'h0077; e.hex = {7'h7F, 7'h7F, 7'h78, 7'h78}; e.cyc = acc + 15 + 14;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        chk("restart_cycle", 32'(cyc), 32'(acc + 15));
        chk("busy_after_restart", 32'(busy), 32'd1);

        // Reset mid-conversion: outputs snap back, no valid for 1234.
        conv(13'd1234, 16'h1234, 28'h0, 1'b0, acc);
        repeat (6) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        chk("midrst_busy",  32'(busy),  32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_bcd",   32'(bcd),   32'd0);
        chk("midrst_hex",   32'(hex),   32'(HEX_RST));
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        conv(13'd1234, 16'h1234, {7'h79, 7'h24, 7'h30, 7'h19}, 1'b1, acc);

        // Start held high, bin ramping: accepts land every 15 cycles.
        wait_idle();
        for (int k = 0; k <= 20; k++) begin
            start = 1'b1;
            bin   = 13'(k);
            @(posedge clk); #1;
            if (k % 15 == 0) begin
                e = model(k);
                e.cyc = cyc + 14;
                sb.push_back(e);
            end
        end
        start = 1'b0;

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        repeat (20) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
